// File: rtl/eth_pkg.sv
// Shared definitions for the GMII UDP frame generator.
//   state_t      : frame sequencer states, in transmit order
//   *_LEN/MIN_PAY: frame geometry in bytes
//   CRC_*        : Ethernet FCS polynomial (reflected form), seed and the
//                  good-frame residue in normal bit order
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_PRE,
    ST_HDR,
    ST_PAY,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam int          PREAMBLE_LEN   = 8;
  localparam int          HDR_LEN        = 42;
  localparam int          MIN_PAY        = 18;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  PRE_BYTE       = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC32 accumulator (reflected, LSB of each byte first).
//   clk   : byte clock
//   clear : reload the seed (takes priority over en)
//   en    : fold din into the running CRC this cycle
//   din   : byte to fold in
//   crc   : running CRC register (not inverted)
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] crc
);

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The sequencer holds clear for every idle cycle, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (clear)   crc <= CRC_INIT;
    else if (en) crc <= crc_next(crc, din);
  end

endmodule

// File: rtl/udp_frame_gen.sv
// GMII Ethernet/IPv4/UDP frame generator, one byte per sys_clk.
//   sys_clk, sys_rst_n : byte clock, asynchronous active-low reset
//   start, pay_len     : frame request and payload length (sampled together)
//   pay_data/valid     : payload stream; pay_ready marks the byte taken
//   gmii_tx_en/er/txd  : registered GMII transmit bus
//   busy               : accepted start through the end of the gap
//   frame_done         : pulse aligned with the last FCS byte on GMII
//   len_err            : pulse for a start with an out-of-range length
//   underrun           : sticky payload starvation flag
module udp_frame_gen
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'h112233445566,
  parameter logic [47:0] SRC_MAC   = 48'h665544332211,
  parameter logic [31:0] SRC_IP    = 32'hC0A80141,
  parameter logic [31:0] DST_IP    = 32'hC0A80180,
  parameter logic [15:0] SRC_PORT  = 16'd1234,
  parameter logic [15:0] DST_PORT  = 16'd1234,
  parameter logic [7:0]  TTL       = 8'd64,
  parameter int          MAX_LEN   = 1472,
  parameter int          LEN_W     = 11,
  parameter int          IFG_BYTES = 12
)(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] pay_len,
  input  logic [7:0]       pay_data,
  input  logic             pay_valid,
  output logic             pay_ready,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic [7:0]       gmii_txd,
  output logic             busy,
  output logic             frame_done,
  output logic             len_err,
  output logic             underrun
);

  // The IDLE cycle that samples start and the CALC cycle are also silent on
  // GMII, so a back-to-back request still sees exactly IFG_BYTES idle bytes.
  localparam int IFG_CYC = IFG_BYTES - 2;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      csum_q;
  logic [15:0]      ip_id;
  logic [15:0]      total_len, udp_len;
  logic [335:0]     hdr_vec;
  logic [8:0]       hdr_idx;
  logic [31:0]      crc, fcs;
  logic             crc_clr, crc_en;
  logic             len_ok, accept;
  logic [7:0]       byte_p0;
  logic             vld_p0, er_p0, done_p0;

  function automatic logic [15:0] ip_csum(input logic [15:0] tot, input logic [15:0] id);
    logic [19:0] s;
    s = 20'h04500 + 20'(tot) + 20'(id) + 20'({TTL, IP_PROTO_UDP})
      + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
      + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    s = 20'(s[15:0]) + 20'(s[19:16]);
    return ~s[15:0];
  endfunction

  assign len_ok    = (pay_len != '0) && (pay_len <= LEN_W'(MAX_LEN));
  assign accept    = start && len_ok && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign total_len = 16'(len_q) + 16'd28;
  assign udp_len   = 16'(len_q) + 16'd8;
  assign fcs       = ~crc;

  assign hdr_vec = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    8'h45, 8'h00, total_len, ip_id, 16'h0000, TTL, IP_PROTO_UDP, csum_q,
                    SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len, 16'h0000};
  // Byte 0 of the header is the top byte of hdr_vec.
  assign hdr_idx = 9'((HDR_LEN - 1) * 8) - {cnt[5:0], 3'b000};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + LEN_W'(1);
    byte_p0   = 8'h00;
    vld_p0    = 1'b0;
    er_p0     = 1'b0;
    done_p0   = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    pay_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        crc_clr = 1'b1;
        cnt_nxt = '0;
        if (accept) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        crc_clr   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_PRE;
      end
      ST_PRE: begin
        vld_p0  = 1'b1;
        byte_p0 = PRE_BYTE;
        if (cnt == LEN_W'(PREAMBLE_LEN - 1)) begin
          byte_p0   = SFD_BYTE;
          cnt_nxt   = '0;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        vld_p0  = 1'b1;
        crc_en  = 1'b1;
        byte_p0 = hdr_vec[hdr_idx +: 8];
        if (cnt == LEN_W'(HDR_LEN - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_PAY;
        end
      end
      ST_PAY: begin
        vld_p0    = 1'b1;
        crc_en    = 1'b1;
        pay_ready = 1'b1;
        // A starved byte is still spent: the frame length never changes.
        byte_p0   = pay_valid ? pay_data : 8'h00;
        er_p0     = ~pay_valid;
        if (cnt == len_q - LEN_W'(1)) begin
          cnt_nxt   = '0;
          state_nxt = (len_q < LEN_W'(MIN_PAY)) ? ST_PAD : ST_FCS;
        end
      end
      ST_PAD: begin
        vld_p0 = 1'b1;
        crc_en = 1'b1;
        if (cnt == LEN_W'(MIN_PAY - 1) - len_q) begin
          cnt_nxt   = '0;
          state_nxt = ST_FCS;
        end
      end
      ST_FCS: begin
        vld_p0  = 1'b1;
        byte_p0 = fcs[{cnt[1:0], 3'b000} +: 8];
        if (cnt[1:0] == 2'd3) begin
          done_p0   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_IFG;
        end
      end
      ST_IFG: begin
        if (cnt == LEN_W'(IFG_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  crc32_d8 u_crc (
    .clk   (sys_clk),
    .clear (crc_clr),
    .en    (crc_en),
    .din   (byte_p0),
    .crc   (crc)
  );

  // p0 -> GMII output register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ip_id      <= 16'h0000;
      underrun   <= 1'b0;
      len_err    <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      gmii_txd   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      len_err    <= start && !len_ok && (state == ST_IDLE);
      gmii_tx_en <= vld_p0;
      gmii_tx_er <= er_p0;
      gmii_txd   <= byte_p0;
      frame_done <= done_p0;
      if (accept)                             underrun <= 1'b0;
      else if (state == ST_PAY && !pay_valid) underrun <= 1'b1;
      if (done_p0) ip_id <= ip_id + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept)             len_q  <= pay_len;
    if (state == ST_CALC)   csum_q <= ip_csum(total_len, ip_id);
  end

endmodule
